// File: rtl/scan_unloader_pkg.sv
// Shared types and constants for the scan unloader.
//   state_e        : frame FSM states (IDLE / SHIFT / PARITY)
//   DEFAULT_WIDTH  : default snapshot width in bits
package scan_unloader_pkg;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;
endpackage

// File: rtl/scan_unloader_if.sv
// Capture/serial-out bundle for the scan unloader.
//   CAP_REQ/CAP_DATA : capture request and parallel snapshot (to unloader)
//   SO_RDY           : consumer accepts SO this cycle (to unloader)
//   SO/SO_VLD        : serial bit and its valid (from unloader)
//   SO_SOF/SO_PAR    : first-bit / parity-bit markers (from unloader)
//   BUSY/DONE/OVR    : status, frame-done pulse, ignored-request pulse
// master = producer/consumer side, slave = the unloader.
interface scan_unloader_if
  import scan_unloader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             CAP_REQ;
  logic [WIDTH-1:0] CAP_DATA;
  logic             SO;
  logic             SO_VLD;
  logic             SO_RDY;
  logic             SO_SOF;
  logic             SO_PAR;
  logic             BUSY;
  logic             DONE;
  logic             OVR;

  modport master (
    output CAP_REQ, CAP_DATA, SO_RDY,
    input  SO, SO_VLD, SO_SOF, SO_PAR, BUSY, DONE, OVR
  );

  modport slave (
    input  CAP_REQ, CAP_DATA, SO_RDY,
    output SO, SO_VLD, SO_SOF, SO_PAR, BUSY, DONE, OVR
  );
endinterface

// File: rtl/scan_unloader_dp.sv
// Datapath of the scan unloader: shift register, bit counter, parity latch.
//   CK, RN      : clock, async active-low reset
//   load_i      : capture data_i, counter := WIDTH, parity := ^data_i
//   shift_i     : shift left one bit, count down
//   data_i      : parallel snapshot
//   msb_o       : current serial bit (shift-register MSB)
//   par_o       : latched even-parity bit
//   cnt_one_o   : counter == 1 (last data bit is on SO)
//   cnt_full_o  : counter == WIDTH (first data bit is on SO)
module scan_unloader_dp
  import scan_unloader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o,
  output logic             par_o,
  output logic             cnt_one_o,
  output logic             cnt_full_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic             par_q;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      sr_q  <= '0;
      cnt_q <= '0;
      par_q <= 1'b0;
    end else if (load_i) begin
      sr_q  <= data_i;
      cnt_q <= CW'(WIDTH);
      par_q <= ^data_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
      // Guard keeps the counter from wrapping if shift is ever asserted at 0.
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign msb_o      = sr_q[WIDTH-1];
  assign par_o      = par_q;
  assign cnt_one_o  = (cnt_q == CW'(1));
  assign cnt_full_o = (cnt_q == CW'(WIDTH));
endmodule

// File: rtl/scan_unloader.sv
// Scan unloader: captures a WIDTH-bit snapshot and streams it MSB first over a
// valid/ready serial port, followed by one even-parity bit.
//   CK, RN : clock, async active-low reset (deassertion synchronized outside)
//   bus    : scan_unloader_if.slave (capture request/data, serial out, status)
// All outputs are registers or decodes of registered state; SO_RDY and CAP_REQ
// only reach next-state logic.
module scan_unloader
  import scan_unloader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           CK,
  input  logic           RN,
  scan_unloader_if.slave bus
);
  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   ovr_q, ovr_d;
  logic   load, shift;
  logic   msb, par, cnt_one, cnt_full;

  scan_unloader_dp #(.WIDTH(WIDTH)) u_dp (
    .CK        (CK),
    .RN        (RN),
    .load_i    (load),
    .shift_i   (shift),
    .data_i    (bus.CAP_DATA),
    .msb_o     (msb),
    .par_o     (par),
    .cnt_one_o (cnt_one),
    .cnt_full_o(cnt_full)
  );

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.CAP_REQ) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ovr_d = bus.CAP_REQ;
        if (bus.SO_RDY) begin
          shift = 1'b1;
          if (cnt_one) state_d = PARITY;
        end
      end
      PARITY: begin
        // A request alongside the parity transfer is not flagged: the frame is
        // ending, and a held request is taken in the following IDLE cycle.
        ovr_d = bus.CAP_REQ & ~bus.SO_RDY;
        if (bus.SO_RDY) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.SO     = ((state_q == SHIFT) & msb) | ((state_q == PARITY) & par);
  assign bus.SO_VLD = (state_q != IDLE);
  assign bus.SO_SOF = (state_q == SHIFT) & cnt_full;
  assign bus.SO_PAR = (state_q == PARITY);
  assign bus.BUSY   = (state_q != IDLE);
  assign bus.DONE   = done_q;
  assign bus.OVR    = ovr_q;
endmodule

// File: tb/tb_scan_unloader.sv
module tb_scan_unloader;
  localparam int W = 8;

  logic CK = 1'b0;
  logic RN = 1'b0;

  scan_unloader_if #(.WIDTH(W)) bus ();
  scan_unloader #(.WIDTH(W)) dut (.CK(CK), .RN(RN), .bus(bus));

  always #5 CK = ~CK;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: queue of serial bits still owed to the consumer.
  typedef struct {bit so; bit sof; bit par;} xbit_t;
  xbit_t q[$];
  bit    m_done = 1'b0;
  bit    m_ovr  = 1'b0;

  // Output vector order: {SO, SO_VLD, SO_SOF, SO_PAR, BUSY, DONE, OVR}
  function automatic logic [6:0] act_out();
    return {bus.SO, bus.SO_VLD, bus.SO_SOF, bus.SO_PAR, bus.BUSY, bus.DONE, bus.OVR};
  endfunction

  function automatic logic [6:0] exp_out();
    if (q.size() == 0) return {5'b0, m_done, m_ovr};
    return {q[0].so, 1'b1, q[0].sof, q[0].par, 1'b1, m_done, m_ovr};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_update(input bit cap, input logic [W-1:0] d, input bit rdy);
    bit busy;
    bit last;
    busy   = (q.size() != 0);
    last   = (q.size() == 1);
    m_done = busy && rdy && last;
    m_ovr  = cap && busy && !(rdy && last);
    if (busy && rdy) void'(q.pop_front());
    if (!busy && cap) begin
      for (int i = W - 1; i >= 0; i--) q.push_back('{d[i], (i == W - 1), 1'b0});
      q.push_back('{^d, 1'b0, 1'b1});
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_done = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // Called at a negedge: compare against the model, drive inputs, advance one cycle.
  task automatic cyc(input bit cap, input logic [W-1:0] d, input bit rdy);
    check("model", 16'(act_out()), 16'(exp_out()));
    bus.CAP_REQ  = cap;
    bus.CAP_DATA = d;
    bus.SO_RDY   = rdy;
    @(posedge CK);
    model_update(cap, d, rdy);
    @(negedge CK);
  endtask

  // One frame with optional 3-cycle stall and optional stray request, shown
  // bit index counted 1..W (W+1 = parity).
  task automatic run_frame(input logic [7:0] d, input int stall_at, input int ovr_at,
                           output logic [8:0] got, output int novr, output int ndone);
    int  nx;
    int  stalls;
    bit  ovr_sent;
    bit  rdy;
    bit  cap;
    nx = 0; stalls = 0; ovr_sent = 0; got = '0; novr = 0; ndone = 0;
    cyc(1'b1, d, 1'b1);
    for (int c = 0; c < 20; c++) begin
      rdy = 1'b1;
      cap = 1'b0;
      if (bus.SO_VLD && (nx + 1 == stall_at) && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
        check("stall_hold", 16'({bus.SO, bus.SO_VLD}), 16'(2'b11));
      end
      if (bus.SO_VLD && (nx + 1 == ovr_at) && !ovr_sent) begin
        cap = 1'b1;
        ovr_sent = 1'b1;
      end
      if (bus.OVR)  novr++;
      if (bus.DONE) ndone++;
      if (bus.SO_VLD && rdy) begin
        got = {got[7:0], bus.SO};
        nx++;
      end
      cyc(cap, 8'hFF, rdy);
    end
  endtask

  typedef struct {bit cap; logic [7:0] d; bit rdy; logic [6:0] exp;} vec_t;
  vec_t tbl[12];

  initial begin
    logic [8:0] got;
    int novr, ndone, nbound;
    logic [7:0] sel;

    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 7'b0000000};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 7'b1110100};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 7'b0100100};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 7'b1100100};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 7'b0100100};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 7'b0100100};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 7'b1100100};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 7'b0100100};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 7'b1100100};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 7'b0101100};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 7'b0000010};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 7'b0000000};

    bus.CAP_REQ = 1'b0; bus.CAP_DATA = '0; bus.SO_RDY = 1'b0;
    @(negedge CK); @(negedge CK);
    check("reset_state", 16'(act_out()), 16'h0);
    RN = 1'b1;
    @(negedge CK);

    // 0xA5 frame, ready always high: cycle-exact table.
    for (int i = 0; i < 12; i++) begin
      check($sformatf("tbl_a5[%0d]", i), 16'(act_out()), 16'(tbl[i].exp));
      cyc(tbl[i].cap, tbl[i].d, tbl[i].rdy);
    end

    // 0x07: trailing parity 1.
    run_frame(8'h07, 0, 0, got, novr, ndone);
    check("frame_07", 16'(got), 16'(9'b000001111));
    check("frame_07_done", 16'(ndone), 16'd1);

    // 0xA5 with 3-cycle stall on bit 3.
    run_frame(8'hA5, 3, 0, got, novr, ndone);
    check("frame_stall", 16'(got), 16'(9'b101001010));

    // Stray request with 0xFF during bit 5.
    run_frame(8'hA5, 0, 5, got, novr, ndone);
    check("frame_ovr", 16'(got), 16'(9'b101001010));
    check("ovr_count", 16'(novr), 16'd1);

    // Reset at bit 4 aborts the frame.
    cyc(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
    check("bit4_shown", 16'({bus.SO, bus.SO_VLD}), 16'(2'b01));
    #2 RN = 1'b0;
    #1 check("async_rst", 16'(act_out()), 16'h0);
    model_reset();
    @(negedge CK);
    check("rst_no_done", 16'(act_out()), 16'h0);
    RN = 1'b1;
    @(negedge CK);
    run_frame(8'h3C, 0, 0, got, novr, ndone);
    check("frame_3c", 16'(got), 16'(9'b001111000));

    // Request held high, data alternating: back-to-back frames.
    sel = 8'h01; ndone = 0; nbound = 0;
    for (int c = 0; c < 31; c++) begin
      if (bus.DONE) ndone++;
      if ((bus.DONE || bus.SO_SOF) && bus.OVR) nbound++;
      if (!bus.BUSY && !bus.DONE && c != 0) nbound++;
      if (!bus.BUSY) begin
        cyc(1'b1, sel, 1'b1);
        sel = (sel == 8'h01) ? 8'h80 : 8'h01;
      end else begin
        cyc(1'b1, sel, 1'b1);
      end
    end
    check("b2b_done", 16'(ndone), 16'd3);
    check("b2b_boundary", 16'(nbound), 16'd0);
    for (int c = 0; c < 12; c++) cyc(1'b0, 8'h00, 1'b1);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++)
      cyc(($urandom_range(7) == 0), 8'($urandom), ($urandom_range(3) != 0));
    for (int c = 0; c < 40; c++) cyc(1'b0, 8'h00, 1'b1);
    check("drained", 16'(act_out()), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/scan_unloader.md
SCAN_UNLOADER -- requirements
Module: scan_unloader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the captured snapshot width in bits; legal range 2..64.
REQ-002 The block SHALL have port CK, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port RN, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port CAP_REQ, input, 1 bit: capture request, sampled on CK.
REQ-005 The block SHALL have port CAP_DATA, input, WIDTH bits: parallel snapshot of netlist flop Q outputs.
REQ-006 The block SHALL have port SO, output, 1 bit: serial data out.
REQ-007 The block SHALL have port SO_VLD, output, 1 bit: SO holds a valid bit.
REQ-008 The block SHALL have port SO_RDY, input, 1 bit: the consumer accepts SO this cycle.
REQ-009 The block SHALL have port SO_SOF, output, 1 bit: the current SO is the first bit of a frame.
REQ-010 The block SHALL have port SO_PAR, output, 1 bit: the current SO is the trailing parity bit.
REQ-011 The block SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have port DONE, output, 1 bit: one-cycle pulse marking frame completion.
REQ-013 The block SHALL have port OVR, output, 1 bit: one-cycle pulse marking a capture request that was ignored.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, PARITY.
REQ-015 A transfer SHALL occur on any rising CK edge where SO_VLD=1 and SO_RDY=1.
REQ-016 IDLE with CAP_REQ=1 at a CK edge: load CAP_DATA into the shift register, load bit counter with WIDTH, latch parity = XOR of CAP_DATA, go to SHIFT.
REQ-017 In SHIFT, SO_VLD SHALL be 1 and SO SHALL equal shift-register MSB; the frame is sent MSB first.
REQ-018 SO_SOF SHALL be 1 only while the counter equals WIDTH in SHIFT.
REQ-019 On each SHIFT transfer: shift left by 1, decrement counter; when the counter reaches 1, that transfer SHALL move the FSM to PARITY.
REQ-020 In PARITY, SO SHALL equal the latched even-parity bit, with SO_VLD=1 and SO_PAR=1.
REQ-021 The PARITY transfer SHALL return the FSM to IDLE, and DONE SHALL be 1 for exactly the following cycle.
REQ-022 A frame SHALL be exactly WIDTH+1 transfers.
REQ-023 With SO_VLD=1 and SO_RDY=0, SO, SO_SOF, SO_PAR and the state SHALL hold unchanged; SO_VLD SHALL never deassert before its transfer.
REQ-024 CAP_REQ=1 in SHIFT or PARITY SHALL be ignored: it does not disturb the frame and produces OVR=1 on the next cycle.
REQ-025 CAP_REQ=1 in the cycle DONE=1 SHALL be accepted, because the FSM is already in IDLE; zero dead cycles between frames.
REQ-026 The counter width SHALL be clog2(WIDTH+1) bits and SHALL never underflow or wrap.
REQ-027 In IDLE, SO, SO_VLD, SO_SOF and SO_PAR SHALL be 0.
REQ-028 Every output SHALL come directly from a register or from a decode of state only; there SHALL be no combinational path from SO_RDY or CAP_REQ to any output.

Reset
REQ-029 RN=0 SHALL force, asynchronously: state IDLE; shift register, counter and parity register 0; SO, SO_VLD, SO_SOF, SO_PAR, BUSY, DONE and OVR all 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no DONE pulse; the first CAP_REQ after RN rises SHALL start a clean frame.
REQ-031 RN deassertion SHALL be synchronized externally; the block SHALL have no internal reset synchronizer.

Structure
REQ-032 The package scan_unloader_pkg SHALL hold the state enum typedef (IDLE/SHIFT/PARITY) and the constant DEFAULT_WIDTH=32.
REQ-033 The shift register, counter and parity latch SHALL sit in one sub-module, scan_unloader_dp; the FSM SHALL stay in the top level.

Verification
REQ-034 WIDTH=8, CAP_DATA=0xA5, SO_RDY=1 constant -> SO sequence 1,0,1,0,0,1,0,1 then parity 0; SO_SOF on bit 1 only; DONE on cycle 11 after CAP_REQ.
REQ-035 WIDTH=8, CAP_DATA=0x07 -> SO sequence 0,0,0,0,0,1,1,1 then parity 1 with SO_PAR=1.
REQ-036 SO_RDY=0 for 3 cycles at bit 3 of 0xA5 -> SO=1 and SO_VLD=1 held stable for those 3 cycles; frame otherwise identical to REQ-034.
REQ-037 CAP_REQ pulse with CAP_DATA=0xFF during bit 5 of a 0xA5 frame -> OVR pulses once; serial output still 0xA5 plus parity 0.
REQ-038 RN pulsed low at bit 4 -> all outputs 0 immediately, no DONE; then CAP_REQ with 0x3C -> clean frame 0,0,1,1,1,1,0,0, parity 0.
REQ-039 CAP_REQ held high continuously with CAP_DATA alternating 0x01/0x80 -> back-to-back frames with no idle cycle; no OVR at frame boundaries.
